// File: rtl/traffic_light_xing.sv
// Two-approach (NS main / EW side) traffic light controller with all-red clearance,
// pedestrian green shortening and a remaining-time countdown. Optional night flash: TL_NIGHT_MODE_EN.
module traffic_light_xing #(
  parameter int F_CLK     = 50000000,
  parameter int F_TICK    = 1,
  parameter int T_GREEN   = 30,
  parameter int T_YELLOW  = 5,
  parameter int T_ALLRED  = 2,
  parameter int T_PED_CUT = 5,
  parameter int CNT_W     = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ped_req,
  input  logic             night,
  output logic [2:0]       led_ns,
  output logic [2:0]       led_ew,
  output logic [CNT_W-1:0] remain,
  output logic             ped_wait,
  output logic             tick
);

  localparam int DIV   = F_CLK / F_TICK;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [CNT_W-1:0] DUR_GREEN  = CNT_W'(T_GREEN);
  localparam logic [CNT_W-1:0] DUR_YELLOW = CNT_W'(T_YELLOW);
  localparam logic [CNT_W-1:0] DUR_ALLRED = CNT_W'(T_ALLRED);
  localparam logic [CNT_W-1:0] DUR_CUT    = CNT_W'(T_PED_CUT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [2:0] LAMP_GREEN  = 3'b011;
  localparam logic [2:0] LAMP_YELLOW = 3'b101;
  localparam logic [2:0] LAMP_RED    = 3'b110;
`ifdef TL_NIGHT_MODE_EN
  localparam logic [2:0] LAMP_OFF    = 3'b111;
`endif

  typedef enum logic [2:0] {
    ALLRED_B  = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_A  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5
`ifdef TL_NIGHT_MODE_EN
    ,
    NIGHT     = 3'd6
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [DIV_W-1:0] divCnt_q, divCnt_d;
  logic             pedWait_q, pedWait_d;
  logic [2:0]       ledNs_q, ledNs_d;
  logic [2:0]       ledEw_q, ledEw_d;
  logic             tickNow;
  logic             pedPending;

`ifdef TL_NIGHT_MODE_EN
  logic             flash_q, flash_d;
`else
  logic             unusedNight;
  assign unusedNight = night;
`endif

  function automatic state_t nextOf(input state_t s);
    case (s)
      ALLRED_B:  nextOf = NS_GREEN;
      NS_GREEN:  nextOf = NS_YELLOW;
      NS_YELLOW: nextOf = ALLRED_A;
      ALLRED_A:  nextOf = EW_GREEN;
      EW_GREEN:  nextOf = EW_YELLOW;
      EW_YELLOW: nextOf = ALLRED_B;
      default:   nextOf = ALLRED_B;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] durOf(input state_t s);
    case (s)
      NS_GREEN, EW_GREEN:   durOf = DUR_GREEN;
      NS_YELLOW, EW_YELLOW: durOf = DUR_YELLOW;
      ALLRED_A, ALLRED_B:   durOf = DUR_ALLRED;
      default:              durOf = '0;
    endcase
  endfunction

  always_comb begin
    divCnt_d = (divCnt_q == DIV_LAST) ? '0 : divCnt_q + DIV_ONE;
  end

  assign tickNow = (divCnt_q == DIV_LAST);

  // A request seen this very cycle already counts, so a cut on a tick cycle overrides the decrement.
  assign pedPending = pedWait_q | ped_req;

  always_comb begin
    state_d   = state_q;
    remain_d  = remain_q;
    pedWait_d = pedPending;
`ifdef TL_NIGHT_MODE_EN
    flash_d   = flash_q;
`endif

    if (tickNow) begin
      if (remain_q == CNT_ONE) begin
        state_d  = nextOf(state_q);
        remain_d = durOf(nextOf(state_q));
      end else begin
        remain_d = remain_q - CNT_ONE;
      end
    end

    if ((state_q == NS_GREEN) && pedPending && (remain_q > DUR_CUT)) begin
      remain_d = DUR_CUT;
    end

`ifdef TL_NIGHT_MODE_EN
    // Night overrides the whole cycle; leaving it always restarts from the clearance interval.
    if (state_q == NIGHT) begin
      if (!night) begin
        state_d  = ALLRED_B;
        remain_d = DUR_ALLRED;
        flash_d  = 1'b0;
      end else begin
        state_d  = NIGHT;
        remain_d = '0;
        if (tickNow) begin
          flash_d = ~flash_q;
        end
      end
    end else if (night) begin
      state_d  = NIGHT;
      remain_d = '0;
      flash_d  = 1'b1;
    end
`endif

    if ((state_d == EW_GREEN) && (state_q != EW_GREEN)) begin
      pedWait_d = 1'b0;
    end
  end

  // Lamps are decoded from the next state so they register alongside it.
  always_comb begin
    ledNs_d = LAMP_RED;
    ledEw_d = LAMP_RED;
    case (state_d)
      NS_GREEN:  ledNs_d = LAMP_GREEN;
      NS_YELLOW: ledNs_d = LAMP_YELLOW;
      EW_GREEN:  ledEw_d = LAMP_GREEN;
      EW_YELLOW: ledEw_d = LAMP_YELLOW;
`ifdef TL_NIGHT_MODE_EN
      NIGHT: begin
        ledNs_d = flash_d ? LAMP_YELLOW : LAMP_OFF;
        ledEw_d = flash_d ? LAMP_YELLOW : LAMP_OFF;
      end
`endif
      default: begin
        ledNs_d = LAMP_RED;
        ledEw_d = LAMP_RED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ALLRED_B;
      remain_q  <= DUR_ALLRED;
      divCnt_q  <= '0;
      pedWait_q <= 1'b0;
      ledNs_q   <= LAMP_RED;
      ledEw_q   <= LAMP_RED;
`ifdef TL_NIGHT_MODE_EN
      flash_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      remain_q  <= remain_d;
      divCnt_q  <= divCnt_d;
      pedWait_q <= pedWait_d;
      ledNs_q   <= ledNs_d;
      ledEw_q   <= ledEw_d;
`ifdef TL_NIGHT_MODE_EN
      flash_q   <= flash_d;
`endif
    end
  end

  assign led_ns   = ledNs_q;
  assign led_ew   = ledEw_q;
  assign remain   = remain_q;
  assign ped_wait = pedWait_q;
  assign tick     = tickNow;

endmodule

// File: tb/tb_traffic_light_xing.sv
// Directed bench for traffic_light_xing with DIV=10, green 6, yellow 2, all-red 1, ped cut 2.
// Night-mode steps follow TL_NIGHT_MODE_EN the same way the design does.
module tb_traffic_light_xing;

  localparam int CNT_W = 7;

  localparam logic [7:0] GRN = 8'h03;
  localparam logic [7:0] YEL = 8'h05;
  localparam logic [7:0] RED = 8'h06;
`ifdef TL_NIGHT_MODE_EN
  localparam logic [7:0] OFF = 8'h07;
`endif

  logic             clk;
  logic             rst_n;
  logic             ped_req;
  logic             night;
  logic [2:0]       led_ns;
  logic [2:0]       led_ew;
  logic [CNT_W-1:0] remain;
  logic             ped_wait;
  logic             tick;

  int vectors     = 0;
  int miscompares = 0;

  // Expected lamps/remain after each of the 18 ticks of one full cycle, starting from NS_GREEN=6.
  logic [7:0] expNs  [18] = '{GRN, GRN, GRN, GRN, GRN, YEL, YEL, RED, RED,
                              RED, RED, RED, RED, RED, RED, RED, RED, GRN};
  logic [7:0] expEw  [18] = '{RED, RED, RED, RED, RED, RED, RED, RED, GRN,
                              GRN, GRN, GRN, GRN, GRN, YEL, YEL, RED, RED};
  logic [7:0] expRem [18] = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd2, 8'd1, 8'd1, 8'd6,
                              8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd2, 8'd1, 8'd1, 8'd6};

  traffic_light_xing #(
    .F_CLK    (10),
    .F_TICK   (1),
    .T_GREEN  (6),
    .T_YELLOW (2),
    .T_ALLRED (1),
    .T_PED_CUT(2),
    .CNT_W    (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ped_req (ped_req),
    .night   (night),
    .led_ns  (led_ns),
    .led_ew  (led_ew),
    .remain  (remain),
    .ped_wait(ped_wait),
    .tick    (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clkN(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic rstN, input logic ped, input logic nt);
    rst_n   = rstN;
    ped_req = ped;
    night   = nt;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkLamps(input string tag, input logic [7:0] ns, input logic [7:0] ew,
                            input logic [7:0] rem);
    checkOutput({tag, " led_ns"}, 8'(led_ns), ns);
    checkOutput({tag, " led_ew"}, 8'(led_ew), ew);
    checkOutput({tag, " remain"}, 8'(remain), rem);
  endtask

  initial begin
    $display("[TB] start");
    applyStimulus(1'b0, 1'b0, 1'b0);
    clkN(3);
    checkLamps("reset", RED, RED, 8'd1);
    checkOutput("reset ped_wait", 8'(ped_wait), 8'd0);
    checkOutput("reset tick", 8'(tick), 8'd0);

    applyStimulus(1'b1, 1'b0, 1'b0);
    clkN(8);
    checkOutput("pre first tick", 8'(tick), 8'd0);
    checkOutput("pre first tick remain", 8'(remain), 8'd1);
    clkN(1);
    checkOutput("first tick", 8'(tick), 8'd1);
    clkN(1);
    checkLamps("first NS green", GRN, RED, 8'd6);
    checkOutput("tick after pulse", 8'(tick), 8'd0);

    $display("[TB] free run");
    for (int i = 0; i < 18; i++) begin
      clkN(10);
      checkLamps($sformatf("cycle tick %0d", i + 1), expNs[i], expEw[i], expRem[i]);
    end

    $display("[TB] ped request in NS green");
    clkN(10);
    checkOutput("ns green remain 5", 8'(remain), 8'd5);
    applyStimulus(1'b1, 1'b1, 1'b0);
    clkN(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkLamps("cut to 2", GRN, RED, 8'd2);
    checkOutput("cut ped_wait", 8'(ped_wait), 8'd1);
    clkN(9);
    checkLamps("after cut tick", GRN, RED, 8'd1);
    clkN(10);
    checkLamps("yellow after cut", YEL, RED, 8'd2);
    checkOutput("ped_wait in yellow", 8'(ped_wait), 8'd1);
    clkN(29);
    checkOutput("ped_wait before EW", 8'(ped_wait), 8'd1);
    checkLamps("allred A", RED, RED, 8'd1);
    clkN(1);
    checkLamps("EW green entry", RED, GRN, 8'd6);
    checkOutput("ped_wait cleared", 8'(ped_wait), 8'd0);

    $display("[TB] ped request in EW green");
    clkN(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    clkN(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("ped_wait set in EW", 8'(ped_wait), 8'd1);
    clkN(68);
    checkLamps("EW yellow pending", RED, YEL, 8'd1);
    checkOutput("ped_wait through EW yellow", 8'(ped_wait), 8'd1);
    clkN(10);
    checkLamps("allred B pending", RED, RED, 8'd1);
    checkOutput("ped_wait through allred", 8'(ped_wait), 8'd1);
    clkN(10);
    checkLamps("NS green first cycle", GRN, RED, 8'd6);
    clkN(1);
    checkLamps("NS green cut next cycle", GRN, RED, 8'd2);
    clkN(49);
    checkLamps("EW green again", RED, GRN, 8'd6);
    checkOutput("ped_wait cleared again", 8'(ped_wait), 8'd0);

    $display("[TB] ped request coincident with tick");
    clkN(119);
    checkOutput("coincident remain 4", 8'(remain), 8'd4);
    checkOutput("coincident tick", 8'(tick), 8'd1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    clkN(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkLamps("cut wins over tick", GRN, RED, 8'd2);
    checkOutput("coincident ped_wait", 8'(ped_wait), 8'd1);
    clkN(10);
    checkLamps("below cut no reload", GRN, RED, 8'd1);

    $display("[TB] reset mid operation");
    applyStimulus(1'b0, 1'b0, 1'b0);
    clkN(1);
    checkLamps("mid reset", RED, RED, 8'd1);
    checkOutput("mid reset ped_wait", 8'(ped_wait), 8'd0);
    checkOutput("mid reset tick", 8'(tick), 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    clkN(8);
    checkOutput("divider restarted", 8'(tick), 8'd0);
    clkN(1);
    checkOutput("tick after reset", 8'(tick), 8'd1);
    clkN(1);
    checkLamps("NS green after reset", GRN, RED, 8'd6);

    clkN(115);
    checkLamps("mid EW green", RED, GRN, 8'd4);
`ifdef TL_NIGHT_MODE_EN
    $display("[TB] night mode");
    applyStimulus(1'b1, 1'b0, 1'b1);
    clkN(1);
    checkLamps("night enter", YEL, YEL, 8'd0);
    clkN(4);
    checkLamps("night flash off", OFF, OFF, 8'd0);
    clkN(10);
    checkLamps("night flash on", YEL, YEL, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    clkN(1);
    checkLamps("night exit", RED, RED, 8'd1);
    clkN(9);
    checkLamps("NS green after night", GRN, RED, 8'd6);
`else
    $display("[TB] night input ignored");
    applyStimulus(1'b1, 1'b0, 1'b1);
    clkN(1);
    checkLamps("night ignored", RED, GRN, 8'd4);
    clkN(4);
    checkLamps("night ignored tick", RED, GRN, 8'd3);
    applyStimulus(1'b1, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
